multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 40 ++++
 rtl/multicycle_ctrl_opcode_dec.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: instruction-type codes,
// RV32 base opcodes, FSM state encodings and the decoded-opcode record.
package multicycle_ctrl_pkg;

   localparam logic [2:0] R_TYPE   = 3'd0;
   localparam logic [2:0] I_TYPE   = 3'd1;
   localparam logic [2:0] S_TYPE   = 3'd2;
   localparam logic [2:0] B_TYPE   = 3'd3;
   localparam logic [2:0] U_TYPE   = 3'd4;
   localparam logic [2:0] J_TYPE   = 3'd5;
   localparam logic [2:0] NOP_TYPE = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] ST_BOOT   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_TRAP   = 3'd6;

   typedef struct packed {
      logic [2:0] instr_type;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_dec.sv
// Combinational opcode decoder: maps instr[6:0] to the instruction-type code
// and the class flags the control FSM needs.
module ctrl_opcode_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output dec_t       dec
);

   // Opcode classification; unknown opcodes are flagged illegal
   always_comb begin
      dec = '{instr_type: NOP_TYPE, is_load: 1'b0, is_store: 1'b0,
              is_branch: 1'b0, is_jump: 1'b0, illegal: 1'b0};
      case (opcode)
         OP_REG:    dec.instr_type = R_TYPE;
         OP_IMM:    dec.instr_type = I_TYPE;
         OP_LOAD: begin
            dec.instr_type = I_TYPE;
            dec.is_load    = 1'b1;
         end
         OP_JALR: begin
            dec.instr_type = I_TYPE;
            dec.is_jump    = 1'b1;
         end
         OP_STORE: begin
            dec.instr_type = S_TYPE;
            dec.is_store   = 1'b1;
         end
         OP_BRANCH: begin
            dec.instr_type = B_TYPE;
            dec.is_branch  = 1'b1;
         end
         OP_LUI:    dec.instr_type = U_TYPE;
         OP_AUIPC:  dec.instr_type = U_TYPE;
         OP_JAL: begin
            dec.instr_type = J_TYPE;
            dec.is_jump    = 1'b1;
         end
         default: begin
            dec.instr_type = NOP_TYPE;
            dec.illegal    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (BOOT/FETCH/DECODE/EXEC/MEM/WB/TRAP) for the RISC-V core.
// Optional retired-instruction counter built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 mem_ready,
   input  logic                 branch_taken,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_sel,
   output logic                 rf_we,
   output logic [2:0]           instr_type,
   output logic                 illegal,
   output logic [31:0]          instret
);

   logic [2:0] state_r;
   logic [2:0] state_nxt_s;
   dec_t       dec_s;
   logic [2:0] type_r;
   logic       is_load_r;
   logic       is_store_r;
   logic       is_branch_r;
   logic       is_jump_r;
   logic       illegal_r;
   logic       unused_instr_s;

   assign unused_instr_s = ^instr[WORD_SIZE-1:7];

   ctrl_opcode_dec u_dec (
      .opcode (instr[6:0]),
      .dec    (dec_s)
   );

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT:   state_nxt_s = ST_FETCH;
         ST_FETCH:  state_nxt_s = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: state_nxt_s = dec_s.illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            if (is_load_r || is_store_r) begin
               state_nxt_s = ST_MEM;
            end else if (is_branch_r) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_MEM: begin
            if (!mem_ready) begin
               state_nxt_s = ST_MEM;
            end else if (is_store_r) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_WB:     state_nxt_s = ST_FETCH;
         ST_TRAP:   state_nxt_s = ST_TRAP;
         default:   state_nxt_s = ST_BOOT;
      endcase
   end

   // Strobes decode from state; only ir_we and the store pc_we see mem_ready
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = 1'b0;
      rf_we   = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
         end
         ST_EXEC: begin
            if (is_branch_r) begin
               pc_we  = 1'b1;
               pc_sel = branch_taken;
            end else begin
               pc_we  = 1'b0;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store_r;
            pc_we   = is_store_r & mem_ready;
         end
         ST_WB: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            pc_sel = is_jump_r;
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   // State register and decode capture (decode results held until next DECODE)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BOOT;
         type_r      <= NOP_TYPE;
         is_load_r   <= 1'b0;
         is_store_r  <= 1'b0;
         is_branch_r <= 1'b0;
         is_jump_r   <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_DECODE) begin
            type_r      <= dec_s.instr_type;
            is_load_r   <= dec_s.is_load;
            is_store_r  <= dec_s.is_store;
            is_branch_r <= dec_s.is_branch;
            is_jump_r   <= dec_s.is_jump;
            illegal_r   <= illegal_r | dec_s.illegal;
         end
      end
   end

   assign instr_type = type_r;
   assign illegal    = illegal_r;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instret_r;

   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_r <= 32'd0;
      end else if (pc_we) begin
         instret_r <= instret_r + 32'd1;
      end
   end

   assign instret = instret_r;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand sequences for
// the illegal-opcode trap and reset in the middle of a fetch.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, illegal;
   logic [2:0]  instr_type;
   logic [31:0] instret;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_instret = 32'd0;

   typedef struct {
      logic [31:0] instr;
      int          fw;
      int          mw;
      logic        bt;
      logic [2:0]  exp_type;
      int          exp_cyc;
      int          exp_rf;
      int          exp_memwe;
      int          exp_memreq;
      logic        exp_sel;
   } vec_t;

   vec_t vecs[11];

   multicycle_ctrl #(.WORD_SIZE(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .rf_we        (rf_we),
      .instr_type   (instr_type),
      .illegal      (illegal),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic retire_model();
`ifdef CTRL_PERF_CNT_EN
      exp_instret = exp_instret + 32'd1;
`else
      exp_instret = 32'd0;
`endif
   endtask

   // Runs one instruction starting at the FETCH cycle that the next negedge shows
   task automatic run_vec(input vec_t v, input int idx);
      int  cyc = 0, rf_c = 0, mwe_c = 0, mreq_c = 0, pcwe_c = 0, acc = 0;
      bit  in_fetch = 1'b1;
      bit  done = 1'b0;
      logic       sel_seen = 1'b0;
      logic [2:0] type_seen = 3'd0;
      instr = v.instr;
      branch_taken = v.bt;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req) mem_ready = (acc >= (in_fetch ? v.fw : v.mw));
         else         mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (c == 0) begin
            chk($sformatf("v%0d fetch_entry", idx), {30'd0, mem_req, mem_we}, 32'b10);
            chk($sformatf("v%0d instret", idx), instret, exp_instret);
         end
         if (mem_req) begin mreq_c++; acc++; end
         if (mem_we) mwe_c++;
         if (rf_we) rf_c++;
         if (ir_we) begin in_fetch = 1'b0; acc = 0; end
         if (pc_we) begin
            pcwe_c++;
            sel_seen = pc_sel;
            type_seen = instr_type;
            cyc = c + 1;
            done = 1'b1;
         end
      end
      chk($sformatf("v%0d pc_we_count", idx), pcwe_c, 1);
      chk($sformatf("v%0d cycles", idx), cyc, v.exp_cyc);
      chk($sformatf("v%0d instr_type", idx), {29'd0, type_seen}, {29'd0, v.exp_type});
      chk($sformatf("v%0d rf_we_cycles", idx), rf_c, v.exp_rf);
      chk($sformatf("v%0d mem_we_cycles", idx), mwe_c, v.exp_memwe);
      chk($sformatf("v%0d mem_req_cycles", idx), mreq_c, v.exp_memreq);
      chk($sformatf("v%0d pc_sel", idx), {31'd0, sel_seen}, {31'd0, v.exp_sel});
      chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, 32'd0);
      retire_model();
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, " strobes"}, {26'd0, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we}, 32'd0);
      chk({nm, " instr_type"}, {29'd0, instr_type}, {29'd0, NOP_TYPE});
      chk({nm, " illegal"}, {31'd0, illegal}, 32'd0);
      chk({nm, " instret"}, instret, 32'd0);
   endtask

   initial begin
      int strobe_hits;
      //            instr          fw mw bt    type     cyc rf mwe mreq sel
      vecs[0]  = '{32'h0223_8693, 0, 0, 1'b0, I_TYPE,  4, 1, 0, 1, 1'b0}; // addi
      vecs[1]  = '{32'h5862_2c23, 0, 2, 1'b0, S_TYPE,  6, 0, 3, 4, 1'b0}; // sw, 2 waits
      vecs[2]  = '{32'h35bb_8ee3, 0, 0, 1'b1, B_TYPE,  3, 0, 0, 1, 1'b1}; // branch taken
      vecs[3]  = '{32'h35bb_8ee3, 0, 0, 1'b0, B_TYPE,  3, 0, 0, 1, 1'b0}; // branch not taken
      vecs[4]  = '{32'h07c9_fbb7, 0, 0, 1'b0, U_TYPE,  4, 1, 0, 1, 1'b0}; // lui
      vecs[5]  = '{32'h29e4_f36f, 0, 0, 1'b0, J_TYPE,  4, 1, 0, 1, 1'b1}; // jal
      vecs[6]  = '{32'h0002_a283, 0, 1, 1'b0, I_TYPE,  6, 1, 0, 3, 1'b0}; // lw, 1 wait
      vecs[7]  = '{32'h00b5_0533, 2, 0, 1'b1, R_TYPE,  6, 1, 0, 3, 1'b0}; // add, 2 fetch waits
      vecs[8]  = '{32'h0000_80e7, 0, 0, 1'b0, I_TYPE,  4, 1, 0, 1, 1'b1}; // jalr
      vecs[9]  = '{32'h0000_0517, 0, 0, 1'b0, U_TYPE,  4, 1, 0, 1, 1'b0}; // auipc
      vecs[10] = '{32'h0011_2623, 0, 0, 1'b0, S_TYPE,  4, 0, 1, 2, 1'b0}; // sw, no wait

      repeat (2) @(negedge clk);
      #1 chk_reset_state("reset");
      #1 rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Illegal opcode: FETCH, DECODE, then TRAP held with no strobes
      instr = 32'hFFFF_FFFF;
      @(negedge clk); mem_ready = 1'b1; #1;
      chk("illegal fetch ir_we", {31'd0, ir_we}, 32'd1);
      @(negedge clk); #1;
      strobe_hits = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1));
         #1;
         if (c == 0) begin
            chk("trap illegal", {31'd0, illegal}, 32'd1);
            chk("trap instr_type", {29'd0, instr_type}, {29'd0, NOP_TYPE});
         end
         if (mem_req | mem_we | ir_we | pc_we | pc_sel | rf_we) strobe_hits++;
      end
      chk("trap strobes over 20 cycles", strobe_hits, 0);
      chk("trap illegal sticky", {31'd0, illegal}, 32'd1);
      chk("trap instret frozen", instret, exp_instret);

      #1 rst_n = 1'b0;
      #1 chk_reset_state("trap reset");
      exp_instret = 32'd0;
      @(negedge clk); #2 rst_n = 1'b1;

      run_vec(vecs[0], 20);
      run_vec(vecs[2], 21);

      // Reset in the middle of a stalled fetch
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("stalled fetch mem_req", {31'd0, mem_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset_state("mid-fetch reset");
      exp_instret = 32'd0;
      @(negedge clk); #2 rst_n = 1'b1;
      run_vec(vecs[4], 22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
